// File: rtl/usbf_dma_arb_pkg.sv
// Shared types and constants for the endpoint DMA arbiter.
package usbf_dma_arb_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'b00,
    ST_GRANT   = 2'b01,
    ST_RELEASE = 2'b10
  } state_t;

  localparam int BEAT_W = 8;

  function automatic int clog2(input int n);
    int r;
    r = 0;
    while ((1 << r) < n) r++;
    return r;
  endfunction

endpackage

// File: rtl/usbf_rr_pick.sv
// Round-robin selector: first set bit of req searching upward from last+1, wrapping.
module usbf_rr_pick #(
  parameter int N_EP  = 4,
  parameter int SEL_W = 2
) (
  input  logic [N_EP-1:0]  req,
  input  logic [SEL_W-1:0] last,
  output logic [SEL_W-1:0] idx,
  output logic             any
);

  // Walk from the farthest candidate back to the nearest so the nearest hit wins.
  always_comb begin
    int j;
    idx = '0;
    any = 1'b0;
    j   = 0;
    for (int i = N_EP; i >= 1; i--) begin
      j = (int'(last) + i) % N_EP;
      if (req[j]) begin
        idx = SEL_W'(j);
        any = 1'b1;
      end
    end
  end

endmodule

// File: rtl/usbf_dma_arb.sv
// Round-robin arbiter sharing one system DMA req/ack channel among endpoint register files.
//   state      | meaning
//   ST_IDLE    | no grant; pick next eligible endpoint
//   ST_GRANT   | dma_req high, acks forwarded to dma_sel
//   ST_RELEASE | one-cycle gap, record last grant
module usbf_dma_arb
  import usbf_dma_arb_pkg::*;
#(
  parameter int N_EP      = 4,
  parameter int SEL_W     = clog2(N_EP),
  parameter int BURST_MAX = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [N_EP-1:0]  ep_dma_req,
  input  logic [N_EP-1:0]  ep_dma_en,
  output logic [N_EP-1:0]  ep_dma_ack,
  output logic             dma_req,
  input  logic             dma_ack,
  output logic [SEL_W-1:0] dma_sel,
  output logic             dma_busy,
  output logic             spur_ack
);

  localparam int BEAT_SAT = (BURST_MAX > 255) ? 255 : BURST_MAX;
  localparam logic [BEAT_W-1:0] BEAT_CAP  = BEAT_W'(BEAT_SAT);
  localparam logic [BEAT_W-1:0] BEAT_LAST = BEAT_W'(BURST_MAX - 1);

  state_t             state;
  logic [SEL_W-1:0]   last_grant;
  logic [SEL_W-1:0]   pick_idx;
  logic               pick_any;
  logic [BEAT_W-1:0]  beat_cnt;
  logic [N_EP-1:0]    elig;
  logic               sel_req;
  logic               sel_en;
  logic               grant_exit;

  assign elig    = ep_dma_req & ep_dma_en;
  assign sel_req = ep_dma_req[dma_sel];
  assign sel_en  = ep_dma_en[dma_sel];

  // Withdrawal is only honoured in non-ack cycles so a request dropped right after an ack is clean.
  assign grant_exit = (dma_ack && (beat_cnt == BEAT_LAST)) ||
                      (!dma_ack && !sel_req) ||
                      !sel_en;

  usbf_rr_pick #(
    .N_EP  (N_EP),
    .SEL_W (SEL_W)
  ) u_pick (
    .req  (elig),
    .last (last_grant),
    .idx  (pick_idx),
    .any  (pick_any)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= ST_IDLE;
      dma_sel    <= '0;
      last_grant <= SEL_W'(N_EP - 1);
      beat_cnt   <= '0;
      spur_ack   <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          spur_ack <= dma_ack;
          if (pick_any) begin
            dma_sel  <= pick_idx;
            beat_cnt <= '0;
            state    <= ST_GRANT;
          end
        end
        ST_GRANT: begin
          spur_ack <= 1'b0;
          if (dma_ack && (beat_cnt < BEAT_CAP)) beat_cnt <= beat_cnt + 1'b1;
          if (grant_exit) state <= ST_RELEASE;
        end
        ST_RELEASE: begin
          spur_ack   <= dma_ack;
          last_grant <= dma_sel;
          state      <= ST_IDLE;
        end
        default: begin
          spur_ack <= 1'b0;
          state    <= ST_IDLE;
        end
      endcase
    end
  end

  assign dma_req  = (state == ST_GRANT);
  assign dma_busy = (state != ST_IDLE);

  always_comb begin
    ep_dma_ack = '0;
    if (state == ST_GRANT) ep_dma_ack[dma_sel] = dma_ack;
  end

endmodule
